// File: rtl/pc_fetch.sv
// +--------------------------------------------------------------------------+
// | pc_fetch : PC register and IF/ID pipeline register for a MIPS-style core  |
// | Optional macro PC_FETCH_DELAY_SLOT_EN: keep the branch delay slot.        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module pc_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        npc_sel,
    input  logic [31:0] NPC,
    input  logic [31:0] Instr_F,
    output logic [31:0] PC_F,
    output logic [31:0] PC_D,
    output logic [31:0] PC4_D,
    output logic [31:0] Instr_D,
    output logic        valid_D,
    output logic        adel_D
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    logic [31:0] r_pc_f;
    logic [31:0] r_pc_d;
    logic [31:0] r_instr_d;
    logic        r_valid_d;
    logic        r_adel_d;

    logic [31:0] w_pc_next;
    logic        w_misaligned;
    logic        w_flush;

    assign w_pc_next    = npc_sel ? NPC : (r_pc_f + c_PC_STEP);
    assign w_misaligned = (r_pc_f[1:0] != 2'b00);

`ifdef PC_FETCH_DELAY_SLOT_EN
    assign w_flush = 1'b0;
`else
    // Without a delay slot the wrong-path word fetched alongside a taken
    // redirect is squashed into a bubble.
    assign w_flush = npc_sel;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_f <= RESET_PC;
        end else if (!stall) begin
            r_pc_f <= w_pc_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_d    <= RESET_PC - c_PC_STEP;
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
            r_adel_d  <= 1'b0;
        end else if (!stall) begin
            r_pc_d <= r_pc_f;
            if (w_flush) begin
                r_instr_d <= NOP_INSTR;
                r_valid_d <= 1'b0;
                r_adel_d  <= 1'b0;
            end else begin
                // A misaligned fetch never reaches decode as a real opcode.
                r_instr_d <= w_misaligned ? NOP_INSTR : Instr_F;
                r_valid_d <= 1'b1;
                r_adel_d  <= w_misaligned;
            end
        end
    end

    assign PC_F    = r_pc_f;
    assign PC_D    = r_pc_d;
    assign PC4_D   = r_pc_d + c_PC_STEP;
    assign Instr_D = r_instr_d;
    assign valid_D = r_valid_d;
    assign adel_D  = r_adel_d;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// +--------------------------------------------------------------------------+
// | tb_pc_fetch : directed self-checking bench for pc_fetch                   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pc_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        npc_sel;
    logic [31:0] NPC;
    logic [31:0] Instr_F;
    logic [31:0] PC_F;
    logic [31:0] PC_D;
    logic [31:0] PC4_D;
    logic [31:0] Instr_D;
    logic        valid_D;
    logic        adel_D;

    int n_compared;
    int n_mismatched;

    pc_fetch #(
        .RESET_PC  (c_RESET_PC),
        .NOP_INSTR (c_NOP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .npc_sel (npc_sel),
        .NPC     (NPC),
        .Instr_F (Instr_F),
        .PC_F    (PC_F),
        .PC_D    (PC_D),
        .PC4_D   (PC4_D),
        .Instr_D (Instr_D),
        .valid_D (valid_D),
        .adel_D  (adel_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: every address returns a distinct recognisable word.
    function automatic logic [31:0] imem(input logic [31:0] addr);
        return {addr[15:0], ~addr[15:0]};
    endfunction

    assign Instr_F = imem(PC_F);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_d(input string tag, input logic [31:0] pc_d, input logic [31:0] ins,
                           input logic vld, input logic adel);
        check({tag, " PC_D"},    PC_D,    pc_d);
        check({tag, " PC4_D"},   PC4_D,   pc_d + 32'd4);
        check({tag, " Instr_D"}, Instr_D, ins);
        check({tag, " valid_D"}, {31'd0, valid_D}, {31'd0, vld});
        check({tag, " adel_D"},  {31'd0, adel_D},  {31'd0, adel});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset   = 1'b1;
        stall   = 1'b0;
        npc_sel = 1'b0;
        NPC     = 32'h0;
        #1;
        check("rst PC_F", PC_F, 32'h0000_3000);
        check_d("rst", 32'h0000_2FFC, c_NOP, 1'b0, 1'b0);
        step();
        reset = 1'b0;

        // Sequential fetch after reset release
        step();
        check("seq1 PC_F", PC_F, 32'h0000_3004);
        check_d("seq1", 32'h0000_3000, 32'h3000_CFFF, 1'b1, 1'b0);
        step();
        check("seq2 PC_F", PC_F, 32'h0000_3008);
        check_d("seq2", 32'h0000_3004, 32'h3004_CFFB, 1'b1, 1'b0);
        step();
        check("seq3 PC_F", PC_F, 32'h0000_300C);
        check_d("seq3", 32'h0000_3008, 32'h3008_CFF7, 1'b1, 1'b0);

        // Redirect: flush or delay slot
        npc_sel = 1'b1;
        NPC     = 32'h0000_3100;
        step();
        check("redir PC_F", PC_F, 32'h0000_3100);
`ifdef PC_FETCH_DELAY_SLOT_EN
        check_d("redir", 32'h0000_300C, 32'h300C_CFF3, 1'b1, 1'b0);
`else
        check_d("redir", 32'h0000_300C, c_NOP, 1'b0, 1'b0);
`endif
        npc_sel = 1'b0;
        step();
        check("tgt PC_F", PC_F, 32'h0000_3104);
        check_d("tgt", 32'h0000_3100, 32'h3100_CEFF, 1'b1, 1'b0);

        // Stall with pending redirect, still asserted on release
        stall   = 1'b1;
        npc_sel = 1'b1;
        NPC     = 32'h0000_3200;
        step();
        check("stall1 PC_F", PC_F, 32'h0000_3104);
        check_d("stall1", 32'h0000_3100, 32'h3100_CEFF, 1'b1, 1'b0);
        step();
        check("stall2 PC_F", PC_F, 32'h0000_3104);
        check_d("stall2", 32'h0000_3100, 32'h3100_CEFF, 1'b1, 1'b0);
        stall = 1'b0;
        step();
        check("rel PC_F", PC_F, 32'h0000_3200);
`ifdef PC_FETCH_DELAY_SLOT_EN
        check_d("rel", 32'h0000_3104, 32'h3104_CEFB, 1'b1, 1'b0);
`else
        check_d("rel", 32'h0000_3104, c_NOP, 1'b0, 1'b0);
`endif

        // Redirect during stall dropped before release: not latched
        stall   = 1'b1;
        npc_sel = 1'b1;
        NPC     = 32'h0000_3300;
        step();
        check("drop stall PC_F", PC_F, 32'h0000_3200);
        stall   = 1'b0;
        npc_sel = 1'b0;
        step();
        check("drop PC_F", PC_F, 32'h0000_3204);
        check_d("drop", 32'h0000_3200, 32'h3200_CDFF, 1'b1, 1'b0);

        // Misaligned target
        npc_sel = 1'b1;
        NPC     = 32'h0000_3102;
        step();
        check("mis PC_F", PC_F, 32'h0000_3102);
        npc_sel = 1'b0;
        step();
        check("adel PC_F", PC_F, 32'h0000_3106);
        check_d("adel", 32'h0000_3102, c_NOP, 1'b1, 1'b1);

        // Wrap at top of address space
        npc_sel = 1'b1;
        NPC     = 32'hFFFF_FFFC;
        step();
        check("top PC_F", PC_F, 32'hFFFF_FFFC);
        npc_sel = 1'b0;
        step();
        check("wrap PC_F", PC_F, 32'h0000_0000);
        check_d("wrap", 32'hFFFF_FFFC, 32'hFFFC_0003, 1'b1, 1'b0);

        // Asynchronous reset between edges during a stall with redirect
        stall   = 1'b1;
        npc_sel = 1'b1;
        NPC     = 32'h0000_3400;
        step();
        check("pre-rst PC_F", PC_F, 32'h0000_0000);
        #2;
        reset = 1'b1;
        #1;
        check("arst PC_F", PC_F, 32'h0000_3000);
        check_d("arst", 32'h0000_2FFC, c_NOP, 1'b0, 1'b0);
        #1;
        reset   = 1'b0;
        stall   = 1'b0;
        npc_sel = 1'b0;
        step();
        check("post PC_F", PC_F, 32'h0000_3004);
        check_d("post", 32'h0000_3000, 32'h3000_CFFF, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word inserted on a flush.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  hazard stall from decode; freezes PC and the IF/ID register.
REQ-006 npc_sel  input  1  decode-stage jump/branch taken; redirects fetch to NPC.
REQ-007 NPC  input  32  redirect target computed in decode.
REQ-008 Instr_F  input  32  instruction word returned by instruction memory for PC_F, same cycle.
REQ-009 PC_F  output  32  current fetch address to instruction memory.
REQ-010 PC_D  output  32  address of the instruction held in decode.
REQ-011 PC4_D  output  32  PC_D + 4, for decode-stage NPC computation.
REQ-012 Instr_D  output  32  instruction held in decode.
REQ-013 valid_D  output  1  decode slot holds a real fetched instruction, not a bubble.
REQ-014 adel_D  output  1  PC_D was not word-aligned (address error on fetch).

Function
REQ-015 PC register next value: stall=1 -> hold; else npc_sel=1 -> NPC; else PC_F + 4.
REQ-016 stall SHALL have priority over npc_sel; a redirect presented during a stall SHALL be applied on the first non-stalled edge only if npc_sel is still asserted then (no internal latching).
REQ-017 PC + 4 SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
REQ-018 IF/ID register: stall=1 -> hold PC_D, Instr_D, valid_D, adel_D; else capture PC_F, Instr_F, 1, (PC_F[1:0] != 0).
REQ-019 PC4_D SHALL be PC_D + 4 (combinational from the registered PC_D, modulo 2^32).
REQ-020 Misaligned NPC SHALL still be loaded into PC_F unchanged; the fault is reported only via adel_D one cycle later, with Instr_D forced to NOP_INSTR.
REQ-021 Fetch latency: instruction at PC_F appears on Instr_D one edge later when stall=0.
REQ-022 Flush behaviour on redirect is set by the Configuration section; a flush SHALL load Instr_D=NOP_INSTR, valid_D=0, adel_D=0, PC_D=PC_F of the flushed slot.
REQ-023 stall and flush in the same cycle: stall wins; no flush, no capture.

Reset
REQ-024 reset=1 SHALL immediately (without clk) set PC_F=RESET_PC, PC_D=RESET_PC-4, Instr_D=NOP_INSTR, valid_D=0, adel_D=0; PC4_D therefore equals RESET_PC.
REQ-025 Reset asserted mid-stall or mid-redirect SHALL discard both; first fetch after release is RESET_PC.
REQ-026 On the first rising edge after reset deassertion with stall=0, PC_F SHALL become RESET_PC+4 and Instr_D the word at RESET_PC with valid_D=1.

Configuration
REQ-027 Macro PC_FETCH_DELAY_SLOT_EN defined: MIPS branch delay slot; the instruction fetched in the redirect cycle SHALL be captured normally (valid_D=1), no flush ever occurs.
REQ-028 Macro PC_FETCH_DELAY_SLOT_EN undefined: when npc_sel=1 and stall=0, the IF/ID register SHALL be flushed per REQ-022 in the same edge that loads NPC.

Verification
REQ-029 Reset release, stall=0, npc_sel=0, 3 edges -> PC_F 3004, 3008, 300C; PC_D 3000, 3004, 3008; valid_D=1 from edge 1.
REQ-030 PC_F=3008, npc_sel=1, NPC=0000_3100 -> next PC_F=3100; with DELAY_SLOT_EN Instr_D=word@3008, valid_D=1; without, Instr_D=NOP_INSTR, valid_D=0.
REQ-031 stall=1 for 2 edges with npc_sel=1, NPC=3200, then stall=0, npc_sel=1 -> PC_F/PC_D unchanged during stall, PC_F=3200 after release edge.
REQ-032 npc_sel=1, NPC=0000_3102 -> PC_F=3102; next edge adel_D=1, PC_D=3102, Instr_D=NOP_INSTR.
REQ-033 Force PC_F=FFFF_FFFC, stall=0 -> PC_F=0000_0000, PC4_D of that instruction=0000_0000.
REQ-034 Assert reset between clock edges during a stall -> outputs take reset values before next edge; PC_F=RESET_PC.
